// File: rtl/lap_stopwatch_pkg.sv
// Shared types for the lap stopwatch: FSM state encoding and BCD digit.
package lap_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RUN_LAP,
    ST_PAUSED
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/lap_stopwatch_digit.sv
// One BCD decade of the stopwatch count; decades chain through carry.
module bcd_digit_counter
  import lap_stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic carry_in,
  input  logic clear,
  output bcd_t digit,
  output logic carry_out
);

  bcd_t digit_q;
  bcd_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (inc && carry_in) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign carry_out = carry_in && (digit_q == BCD_MAX);
  assign digit     = digit_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Lap stopwatch: prescaled BCD counter with run/pause, lap hold and overflow.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int WRAP       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [4*NUM_DIGITS-1:0] display_bcd,
  output logic                    running,
  output logic                    lap_hold,
  output logic                    overflow,
  output logic                    tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int W   = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [W-1:0]    lap_q, lap_d;
  logic            ovf_q, ovf_d;

  logic [NUM_DIGITS:0] carry;
  logic full;
  logic sat;
  logic inc;
  logic clr_all;

  assign running  = (state_q == ST_RUN) || (state_q == ST_RUN_LAP);
  assign lap_hold = (state_q == ST_RUN_LAP);
  assign tick     = running && (presc_q == DIV_M1);
  assign overflow = ovf_q;

  // carry out of the top decade means every digit is 9
  assign carry[0] = 1'b1;
  assign full     = carry[NUM_DIGITS];
  assign sat      = tick && full && (WRAP == 0);
  assign inc      = tick && !sat;
  assign clr_all  = (state_q == ST_PAUSED) && !start_stop && clear;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_counter u_dig (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc),
      .carry_in  (carry[i]),
      .clear     (clr_all),
      .digit     (count_bcd[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    if (running) presc_d = tick ? '0 : presc_q + PW'(1);
    if (tick && full) ovf_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_stop) begin
          state_d = ST_PAUSED;
        end else if (lap) begin
          state_d = ST_RUN_LAP;
          lap_d   = count_bcd;
        end
      end
      ST_RUN_LAP: begin
        if (start_stop)  state_d = ST_PAUSED;
        else if (clear)  state_d = ST_RUN;
        else if (lap)    lap_d   = count_bcd;
      end
      ST_PAUSED: begin
        if (start_stop) begin
          state_d = ST_RUN;
        end else if (clear) begin
          state_d = ST_IDLE;
          presc_d = '0;
          lap_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // saturating full scale stops the clock on the same edge
    if (sat) state_d = ST_PAUSED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign display_bcd = (state_q == ST_RUN_LAP) ? lap_q : count_bcd;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench: two stopwatches (wrap / saturate) against a behavioural model.
module tb_lap_stopwatch;

  localparam int DIV  = 10;
  localparam int ND   = 2;
  localparam int FULL = 99;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_LAP  = 2;
  localparam int S_PAU  = 3;

  typedef struct {
    int st;
    int pre;
    int cnt;
    int lapv;
    bit ovf;
  } mdl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_stop = 1'b0;
  logic lap = 1'b0;
  logic clear = 1'b0;

  logic [7:0] cw, dw, cs, ds;
  logic rw, hw, ow, tw;
  logic rs, hs, os, ts;

  int checks = 0;
  int errors = 0;
  int ticks = 0;

  mdl_t mw, ms;

  always #5 clk = ~clk;

  lap_stopwatch #(
    .CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(ND), .WRAP(1)
  ) dut_w (
    .clk(clk), .reset(reset), .start_stop(start_stop),
    .lap(lap), .clear(clear), .count_bcd(cw),
    .display_bcd(dw), .running(rw), .lap_hold(hw),
    .overflow(ow), .tick(tw)
  );

  lap_stopwatch #(
    .CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(ND), .WRAP(0)
  ) dut_s (
    .clk(clk), .reset(reset), .start_stop(start_stop),
    .lap(lap), .clear(clear), .count_bcd(cs),
    .display_bcd(ds), .running(rs), .lap_hold(hs),
    .overflow(os), .tick(ts)
  );

  function automatic logic [7:0] bcd(int v);
    logic [7:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic mdl_t zero_m();
    mdl_t z;
    z.st = S_IDLE; z.pre = 0; z.cnt = 0; z.lapv = 0; z.ovf = 1'b0;
    return z;
  endfunction

  function automatic mdl_t step(mdl_t m, bit wrap, bit ss, bit lp, bit cl);
    mdl_t n;
    bit run;
    bit tk;
    bit stop;
    n = m;
    run = (m.st == S_RUN) || (m.st == S_LAP);
    tk = run && (m.pre == DIV - 1);
    stop = 1'b0;
    if (run) n.pre = (m.pre + 1) % DIV;
    if (tk) begin
      if (m.cnt == FULL) begin
        n.ovf = 1'b1;
        if (wrap) n.cnt = 0;
        else stop = 1'b1;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    case (m.st)
      S_IDLE: if (ss) n.st = S_RUN;
      S_RUN: begin
        if (ss) n.st = S_PAU;
        else if (lp) begin n.st = S_LAP; n.lapv = m.cnt; end
      end
      S_LAP: begin
        if (ss) n.st = S_PAU;
        else if (cl) n.st = S_RUN;
        else if (lp) n.lapv = m.cnt;
      end
      default: begin
        if (ss) n.st = S_RUN;
        else if (cl) n = zero_m();
      end
    endcase
    if (stop) n.st = S_PAU;
    return n;
  endfunction

  function automatic logic [19:0] exp_vec(mdl_t m);
    bit run;
    run = (m.st == S_RUN) || (m.st == S_LAP);
    return {bcd(m.cnt), (m.st == S_LAP) ? bcd(m.lapv) : bcd(m.cnt),
            run, m.st == S_LAP, m.ovf, run && (m.pre == DIV - 1)};
  endfunction

  function automatic logic [19:0] vec_w();
    return {cw, dw, rw, hw, ow, tw};
  endfunction

  function automatic logic [19:0] vec_s();
    return {cs, ds, rs, hs, os, ts};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mw <= zero_m();
      ms <= zero_m();
    end else begin
      mw <= step(mw, 1'b1, start_stop, lap, clear);
      ms <= step(ms, 1'b0, start_stop, lap, clear);
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_w", 32'(vec_w()), 32'(exp_vec(mw)));
    chk("model_s", 32'(vec_s()), 32'(exp_vec(ms)));
    if (tw === 1'b1) ticks++;
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(bit ss, bit lp, bit cl);
    start_stop = ss;
    lap = lp;
    clear = cl;
    cyc(1);
    start_stop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;
  endtask

  int c0;

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("reset_state", 32'(vec_w()), 32'h0);

    // 95 cycles of running from zero: nine ticks
    pulse(1, 0, 0);
    ticks = 0;
    cyc(95);
    chk("run95_count", 32'(cw), 32'h09);
    chk("run95_ticks", 32'(ticks), 32'd9);
    chk("run95_running", 32'(rw), 32'd1);

    // lap hold at 0x12
    for (int i = 0; i < 200 && cw != 8'h12; i++) cyc(1);
    chk("reach_12", 32'(cw), 32'h12);
    pulse(0, 1, 0);
    cyc(30);
    chk("lap_disp", 32'(dw), 32'h12);
    chk("lap_count", 32'(cw), 32'h15);
    chk("lap_holdhi", 32'(hw), 32'd1);
    pulse(0, 0, 1);
    chk("lapclr_disp", 32'(dw), 32'(cw));
    chk("lapclr_hold", 32'(hw), 32'd0);

    // pause with partial prescaler period, then resume
    for (int i = 0; i < 20 && mw.pre != 4; i++) cyc(1);
    chk("wait_pre4", 32'(mw.pre), 32'd4);
    pulse(1, 0, 0);
    cyc(50);
    pulse(1, 0, 0);
    c0 = mw.cnt;
    cyc(4);
    chk("resume_tick", 32'(tw), 32'd1);
    chk("resume_hold", 32'(cw), 32'(bcd(c0)));
    cyc(1);
    chk("resume_inc", 32'(cw), 32'(bcd(c0 + 1)));
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    chk("pclr_count", 32'(cw), 32'h00);
    chk("pclr_idle", 32'({rw, hw, ow}), 32'd0);

    // all three pulses together in RUN
    pulse(1, 0, 0);
    cyc(3);
    pulse(1, 1, 1);
    chk("tri_state", 32'({rw, hw}), 32'd0);
    chk("tri_disp", 32'(dw), 32'(cw));
    pulse(0, 0, 1);

    // lap capture on the tick edge at 0x07
    pulse(1, 0, 0);
    for (int i = 0; i < 200 && !(mw.cnt == 7 && mw.pre == 9); i++) cyc(1);
    chk("wait_tick7", 32'(tw), 32'd1);
    pulse(0, 1, 0);
    chk("lap7_disp", 32'(dw), 32'h07);
    chk("lap7_count", 32'(cw), 32'h08);
    pulse(1, 0, 0);
    pulse(0, 0, 1);

    // full scale: wrap vs saturate
    pulse(1, 0, 0);
    cyc(1005);
    chk("wrap_count", 32'(cw), 32'h00);
    chk("wrap_ovf", 32'(ow), 32'd1);
    chk("wrap_run", 32'(rw), 32'd1);
    chk("sat_count", 32'(cs), 32'h99);
    chk("sat_ovf", 32'(os), 32'd1);
    chk("sat_run", 32'(rs), 32'd0);
    pulse(0, 0, 1);
    chk("sat_clr", 32'({cs, os}), 32'd0);

    // randomized pulses
    for (int i = 0; i < 4000; i++) begin
      start_stop = ($urandom_range(0, 39) == 0);
      lap = ($urandom_range(0, 14) == 0);
      clear = ($urandom_range(0, 24) == 0);
      cyc(1);
    end
    start_stop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;

    // asynchronous reset between edges
    pulse(1, 0, 0);
    cyc(37);
    #2 reset = 1'b1;
    #1;
    chk("arst_w", 32'(vec_w()), 32'h0);
    chk("arst_s", 32'(vec_s()), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rel_tick", 32'(tw), 32'd0);
    cyc(1);
    chk("rel_idle", 32'({cw, rw, tw}), 32'd0);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, count resolution in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 Parameter NUM_DIGITS, default 4, number of BCD decades counted, range 1..8.
REQ-004 Parameter WRAP, default 1: 1 = roll over to zero at full scale, 0 = saturate and pause.
REQ-005 clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start_stop  input  1  one-cycle pulse that toggles run/pause.
REQ-008 lap  input  1  one-cycle pulse that captures the lap value.
REQ-009 clear  input  1  one-cycle pulse that zeroes the count when paused or releases lap hold.
REQ-010 count_bcd  output  4*NUM_DIGITS  live count, digit 0 in LSBs.
REQ-011 display_bcd  output  4*NUM_DIGITS  value for the downstream display driver.
REQ-012 running  output  1  high in RUN and RUN_LAP.
REQ-013 lap_hold  output  1  high in RUN_LAP.
REQ-014 overflow  output  1  sticky full-scale flag.
REQ-015 tick  output  1  one-cycle pulse on each count increment.

Function
REQ-016 Inputs are clean synchronous pulses; debouncing and synchronisation are external.
REQ-017 Prescaler counts 0..DIV-1, DIV = CLK_HZ/TICK_HZ; it advances only in RUN/RUN_LAP and holds its value in IDLE/PAUSED, so partial periods resume.
REQ-018 tick SHALL assert in the cycle the prescaler equals DIV-1 while running; count_bcd SHALL update on that same edge (visible one cycle after tick).
REQ-019 Count increments as cascaded decades: a digit at 9 with carry-in goes to 0 and carries; all other digits hold.
REQ-020 FSM states: IDLE, RUN, RUN_LAP, PAUSED.
REQ-021 IDLE: start_stop -> RUN; lap and clear are ignored.
REQ-022 RUN: start_stop -> PAUSED; lap -> RUN_LAP with lap register <= count_bcd; clear is ignored.
REQ-023 RUN_LAP: lap re-captures and stays; clear -> RUN; start_stop -> PAUSED, which releases the hold.
REQ-024 PAUSED: start_stop -> RUN; clear -> IDLE, zeroing count, prescaler, lap register and overflow; lap is ignored.
REQ-025 Priority on simultaneous pulses: start_stop > clear > lap.
REQ-026 Lap capture coinciding with a tick SHALL latch the pre-increment value.
REQ-027 display_bcd = lap register in RUN_LAP, otherwise count_bcd; it is combinational from registers.
REQ-028 At full scale (all digits 9) with a tick: WRAP=1 -> count becomes 0, overflow set, state unchanged; WRAP=0 -> count holds all-9s, overflow set, state -> PAUSED on that edge.
REQ-029 overflow SHALL clear only via clear-to-IDLE or reset.

Reset
REQ-030 On reset assertion, immediately and asynchronously: state=IDLE, prescaler=0, count=0, lap register=0, overflow=0, tick=0; therefore running=0, lap_hold=0, display_bcd=0.
REQ-031 Reset mid-run SHALL discard all counting progress, with no tick in the release cycle.

Structure
REQ-032 Package lap_stopwatch_pkg holds the state enum type and the BCD digit typedef (logic [3:0]).
REQ-033 One sub-module bcd_digit_counter (inc, carry_in, clear, digit, carry_out) is instantiated NUM_DIGITS times via generate.
REQ-034 Prescaler width is $clog2(DIV).

Verification (CLK_HZ=10, TICK_HZ=1, NUM_DIGITS=2 unless stated)
REQ-035 reset, then start_stop, then 95 cycles -> count_bcd=0x09, tick pulses=9, running=1.
REQ-036 Run to count 0x12, pulse lap, then 30 cycles -> display_bcd=0x12, count_bcd=0x15; then clear -> display_bcd=count_bcd, lap_hold=0.
REQ-037 start_stop at prescaler=4, pause 50 cycles, resume -> next tick exactly 5 cycles after resume; clear while paused -> count=0x00, state IDLE.
REQ-038 WRAP=1, run 1000 cycles -> count 0x99 -> 0x00, overflow=1, running=1; WRAP=0 -> count holds 0x99, overflow=1, running=0.
REQ-039 start_stop, lap and clear in the same cycle in RUN -> PAUSED, no lap capture; lap coincident with tick at 0x07 -> lap=0x07.
REQ-040 reset asserted mid-run between clock edges -> all outputs zero before the next edge; tick stays low after release.
